// File: rtl/ifetch_pkg.sv
// rtl/ifetch_pkg.sv - shared types and constants for the instruction fetch stage
package ifetch_pkg;

  localparam int MAX_RV = 32;
  localparam logic [15:0] INS_FAULT_FILL = 16'h0000;
  localparam logic [31:0] DEF_RESET_VEC = 32'h0000_0000;

  // pc is sized for the widest RV; narrower builds zero-extend into it
  typedef struct packed {
    logic [15:0]       parcel;
    logic              fault;
    logic [MAX_RV-1:0] pc;
  } fetch_entry_t;

  function automatic fetch_entry_t make_entry(input logic [15:0] rdata,
                                              input logic fault,
                                              input logic [MAX_RV-1:0] pc);
    fetch_entry_t e;
    e.parcel = fault ? INS_FAULT_FILL : rdata;
    e.fault  = fault;
    e.pc     = pc;
    return e;
  endfunction

endpackage

// File: rtl/ifetch_queue.sv
// rtl/ifetch_queue.sv - small power-of-two FIFO of fetched parcels with flush
module ifetch_queue
  import ifetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         push,
  input  fetch_entry_t                 push_data,
  input  logic                         pop,
  input  logic                         flush,
  output fetch_entry_t                 head,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);

  fetch_entry_t    slots [DEPTH];
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic            do_push;
  logic            do_pop;

  always_comb begin
    full    = (count == CW'(DEPTH));
    empty   = (count == '0);
    do_push = push && !full;
    do_pop  = pop && !empty;
    head    = slots[rd_ptr];
  end

  // Storage needs no reset: count gates every read of it.
  always_ff @(posedge clk) begin
    if (do_push) begin
      slots[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ifetch.sv
// rtl/ifetch.sv - instruction fetch stage: single-outstanding 16-bit reads,
// parcel queue toward the decoder, flush and restart on redirect
module ifetch
  import ifetch_pkg::*;
#(
  parameter int          RV        = 32,
  parameter int          QDEPTH    = 2,
  parameter logic [31:0] RESET_VEC = DEF_RESET_VEC
) (
  input  logic          clk,
  input  logic          reset_n,
  output logic          mem_req,
  output logic [RV-1:0] mem_addr,
  input  logic          mem_gnt,
  input  logic          mem_ack,
  input  logic [15:0]   mem_rdata,
  input  logic          mem_fault,
  input  logic          redirect,
  input  logic [RV-1:0] redirect_pc,
  input  logic          stall,
  output logic [15:0]   ins,
  output logic          idone,
  output logic [RV-1:0] ins_pc,
  output logic          ins_fault
);

  localparam int            CW     = $clog2(QDEPTH+1);
  localparam logic [RV-1:0] PC_RST = RESET_VEC[RV-1:0] & ~RV'(1);

  logic          live;
  logic [RV-1:0] pc;
  logic [RV-1:0] req_pc;
  logic          outstanding;
  logic          discard;
  logic          halted;
  logic          busy;
  logic [15:0]   last_ins;
  logic [RV-1:0] last_pc;
  logic          last_fault;

  logic          grant;
  logic          ack_live;
  logic          push;
  logic          pop;
  fetch_entry_t  push_data;
  fetch_entry_t  q_head;
  logic [CW-1:0] q_count;
  logic          q_full;
  logic          q_empty;
  logic [CW:0]   budget;

  ifetch_queue #(.DEPTH(QDEPTH)) u_queue (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .flush     (redirect),
    .head      (q_head),
    .count     (q_count),
    .full      (q_full),
    .empty     (q_empty)
  );

  assign budget = {1'b0, q_count} + {{CW{1'b0}}, outstanding};

  always_comb begin
    mem_req   = live && !halted && !outstanding && !busy && !q_full &&
                (budget < (CW+1)'(QDEPTH)) && !redirect;
    mem_addr  = pc;
    grant     = mem_req && mem_gnt;
    ack_live  = mem_ack && outstanding && !discard;
    push      = ack_live && !redirect;
    push_data = make_entry(mem_rdata, mem_fault, MAX_RV'(req_pc));
    pop       = !q_empty && !stall && !redirect;
    idone     = pop;
    ins       = pop ? q_head.parcel      : last_ins;
    ins_pc    = pop ? q_head.pc[RV-1:0]  : last_pc;
    ins_fault = pop ? q_head.fault       : last_fault;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      live        <= 1'b0;
      pc          <= PC_RST;
      req_pc      <= PC_RST;
      outstanding <= 1'b0;
      discard     <= 1'b0;
      halted      <= 1'b0;
      last_ins    <= 16'h0000;
      last_pc     <= '0;
      last_fault  <= 1'b0;
    end else begin
      live <= 1'b1;
      if (pop) begin
        last_ins   <= q_head.parcel;
        last_pc    <= q_head.pc[RV-1:0];
        last_fault <= q_head.fault;
      end
      if (redirect) begin
        pc      <= redirect_pc & ~RV'(1);
        halted  <= 1'b0;
        discard <= outstanding && !mem_ack;
        if (mem_ack) outstanding <= 1'b0;
      end else if (grant) begin
        outstanding <= 1'b1;
        req_pc      <= pc;
        pc          <= pc + RV'(2);
      end else if (mem_ack) begin
        outstanding <= 1'b0;
        discard     <= 1'b0;
        if (ack_live && mem_fault) halted <= 1'b1;
      end
    end
  end

  // Survives reset on purpose: a grant taken before reset still owes an ack,
  // and that ack must not be mistaken for the first post-reset fetch.
  always_ff @(posedge clk) begin
    if (grant) begin
      busy <= 1'b1;
    end else if (mem_ack) begin
      busy <= 1'b0;
    end
  end

endmodule
